plane_interp_stepper: RTL and testbench
=======================================

// Module: plane_interp_stepper
// PURPOSE
//  Consumes one plane equation (ddx, ddy, c) from the upstream plane-equation setup stage and walks a
//  rectangular pixel span (tile or triangle bbox), row-major, emitting one interpolated attribute per pixel.
//  The start value is computed once by multiply; after that each value is formed by incremental add:
//  +ddx per pixel, +ddy per row. Output is a valid/ready pixel stream to the texture/shade stage.
// PARAMETERS
//  FRAC_BITS   8   fractional bits of ddx/ddy/c/out_interp (signed fixed point, same format as setup stage)
//  COORD_W     11  width of unsigned integer pixel coordinates and span sizes
//  ACC_W       48  internal accumulator width, signed
// PORTS
//  clock        in   1        single clock, rising edge
//  reset_n      in   1        asynchronous assert, active-low reset
//  setup_valid  in   1        plane + span descriptor valid
//  setup_ready  out  1        high only in IDLE
//  ddx          in   32 s     d(attr)/dx, FRAC_BITS fixed point
//  ddy          in   32 s     d(attr)/dy, FRAC_BITS fixed point
//  c            in   32 s     plane constant, FRAC_BITS fixed point
//  x0, y0       in   COORD_W  span origin, integer pixels
//  width,height in   COORD_W  span size in pixels; 0 allowed
//  out_valid    out  1        pixel output valid
//  out_ready    in   1        downstream accepts pixel
//  out_x,out_y  out  COORD_W  pixel coordinate
//  out_interp   out  32 s     attribute = x*ddx + y*ddy + c, FRAC_BITS fixed point
//  out_last     out  1        final pixel of span
//  done         out  1        one-cycle pulse at span end
// BEHAVIOUR
//  Reset: state IDLE; setup_ready=1; out_valid=0; out_last=0; done=0; out_x/out_y/out_interp=0.
//  FSM: IDLE -> INIT on setup_valid&&setup_ready (capture all inputs into registers).
//    INIT (1 cycle): acc_row = acc = sext(x0*ddx) + sext(y0*ddy) + sext(c) at ACC_W bits; x,y are integers,
//    so there is no shift. If width==0 or height==0, go to IDLE with done=1 and emit no pixels; else go to RUN.
//    RUN: out_valid=1. On out_valid&&out_ready:
//      - not end of row: x+=1; acc+=ddx.
//      - end of row, not last row: x=x0; y+=1; acc_row+=ddy; acc=acc_row+ddy.
//      - last pixel (out_last=1): go to IDLE and pulse done in the next cycle.
//  Latency: setup accepted in cycle N; first out_valid in N+2. Throughput is 1 pixel/clk with no row-change bubble.
//  Backpressure: while out_valid&&!out_ready, out_x/out_y/out_interp/out_last hold stable.
//  out_interp = acc[31:0]; this truncates and wraps. No saturation. The accumulator is exact, so there is no drift.
//  out_last = (x==x0+width-1)&&(y==y0+height-1), registered alongside the data.
//  A new setup is accepted only in IDLE, so there is one idle cycle between spans. setup_valid in other states is ignored.
//  Coordinates: x0+width-1 and y0+height-1 must fit in COORD_W. Coordinate wrap is not checked.
//  Reset mid-span: immediate return to IDLE, out_valid=0, no done pulse. The span is discarded.
//  done and setup_ready both high in the same cycle is legal. Back-to-back setup is allowed on the done cycle.
// STRUCTURE
//  Shared pvr package: FRAC_BITS, COORD_W, ACC_W defaults; state enum {IDLE, INIT, RUN}; ACC_W-bit
//    sign-extend helper.
//  Sub-module plane_init_mult: 3-term start-value MAC (x0*ddx + y0*ddy + c), purely combinational,
//    registered in INIT. Everything else is inline: FSM, x/y counters, accumulators, output register.
// TESTING
//  1) ddx=0x100, ddy=0x200, c=0x1000, x0=2, y0=3, w=2, h=2, out_ready=1
//     -> (2,3)0x1800 (3,3)0x1900 (2,4)0x1A00 (3,4)0x1B00; last on the 4th pixel; done 1 cycle later.
//  2) Same as 1 with out_ready toggled 1,0,0,1,... -> identical sequence; outputs stable while stalled; no loss or duplication.
//  3) w=0, h=5 -> no out_valid; done pulses 2 cycles after setup; setup_ready returns high.
//  4) ddx=-0x80, ddy=0, c=0, x0=0, y0=0, w=4, h=1 -> interp 0x0, 0xFFFFFF80, 0xFFFFFF00, 0xFFFFFE80.
//  5) reset_n low during pixel 2 of a 4x4 span -> out_valid=0 asynchronously; no done; next setup runs cleanly.
//  6) w=640, h=1, ddx=0x7FFFFFFF -> compare out_interp per pixel against a reference model of 32-bit wrap.

Source files
------------

// File: rtl/plane_interp_stepper_pkg.sv
// Shared definitions for the plane interpolation stepper: default widths, FSM states
// and the conversions into the signed accumulator format.
package plane_interp_stepper_pkg;

  localparam int FRAC_BITS = 8;
  localparam int COORD_W   = 11;
  localparam int ACC_W     = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [31:0] v);
    return {{(ACC_W-32){v[31]}}, v};
  endfunction

  // Coordinates are unsigned, so they widen with zeros before a signed multiply.
  function automatic logic signed [ACC_W-1:0] zext_coord(input logic [COORD_W-1:0] v);
    return {{(ACC_W-COORD_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/plane_interp_stepper_if.sv
// Plane/span descriptor input and pixel output stream of the interpolation stepper.
interface plane_interp_stepper_if;
  import plane_interp_stepper_pkg::*;

  logic                      setup_valid;
  logic                      setup_ready;
  logic signed [31:0]        ddx;
  logic signed [31:0]        ddy;
  logic signed [31:0]        c;
  logic [COORD_W-1:0]        x0;
  logic [COORD_W-1:0]        y0;
  logic [COORD_W-1:0]        width;
  logic [COORD_W-1:0]        height;
  logic                      out_valid;
  logic                      out_ready;
  logic [COORD_W-1:0]        out_x;
  logic [COORD_W-1:0]        out_y;
  logic signed [31:0]        out_interp;
  logic                      out_last;
  logic                      done;

  modport master (
    output setup_valid, ddx, ddy, c, x0, y0, width, height, out_ready,
    input  setup_ready, out_valid, out_x, out_y, out_interp, out_last, done
  );

  modport slave (
    input  setup_valid, ddx, ddy, c, x0, y0, width, height, out_ready,
    output setup_ready, out_valid, out_x, out_y, out_interp, out_last, done
  );

endinterface

// File: rtl/plane_interp_stepper_init_mult.sv
// Start value of a span: x0*ddx + y0*ddy + c, exact at accumulator width.
module plane_init_mult
  import plane_interp_stepper_pkg::*;
(
  input  logic [COORD_W-1:0]       x0_i,
  input  logic [COORD_W-1:0]       y0_i,
  input  logic signed [31:0]       ddx_i,
  input  logic signed [31:0]       ddy_i,
  input  logic signed [31:0]       c_i,
  output logic signed [ACC_W-1:0]  start_o
);

  logic signed [ACC_W-1:0] x_term;
  logic signed [ACC_W-1:0] y_term;

  // Integer coordinates times fixed-point slopes stay in the slope's format: no shift.
  assign x_term  = zext_coord(x0_i) * sext_acc(ddx_i);
  assign y_term  = zext_coord(y0_i) * sext_acc(ddy_i);
  assign start_o = x_term + y_term + sext_acc(c_i);

endmodule

// File: rtl/plane_interp_stepper.sv
// Walks a rectangular span row-major, emitting one incrementally interpolated attribute
// per pixel on a valid/ready stream.
module plane_interp_stepper
  import plane_interp_stepper_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  plane_interp_stepper_if.slave   bus
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  state_e                   state_q;
  logic signed [31:0]       ddx_q, ddy_q, c_q;
  logic [COORD_W-1:0]       x0_q, y0_q, w_q, h_q;
  logic [COORD_W-1:0]       x_end_q, y_end_q;
  logic [COORD_W-1:0]       x_q, y_q;
  logic signed [ACC_W-1:0]  acc_q, acc_row_q;
  logic                     setup_ready_q, out_valid_q, last_q, done_q;
  logic signed [ACC_W-1:0]  start_val;
  logic signed [ACC_W-1:0]  acc_row_d;

  plane_init_mult u_init_mult (
    .x0_i    (x0_q),
    .y0_i    (y0_q),
    .ddx_i   (ddx_q),
    .ddy_i   (ddy_q),
    .c_i     (c_q),
    .start_o (start_val)
  );

  assign acc_row_d = acc_row_q + sext_acc(ddy_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ddx_q         <= '0;
      ddy_q         <= '0;
      c_q           <= '0;
      x0_q          <= '0;
      y0_q          <= '0;
      w_q           <= '0;
      h_q           <= '0;
      x_end_q       <= '0;
      y_end_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      acc_q         <= '0;
      acc_row_q     <= '0;
      setup_ready_q <= 1'b1;
      out_valid_q   <= 1'b0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.setup_valid && setup_ready_q) begin
            ddx_q         <= bus.ddx;
            ddy_q         <= bus.ddy;
            c_q           <= bus.c;
            x0_q          <= bus.x0;
            y0_q          <= bus.y0;
            w_q           <= bus.width;
            h_q           <= bus.height;
            setup_ready_q <= 1'b0;
            state_q       <= ST_INIT;
          end
        end
        ST_INIT: begin
          acc_q     <= start_val;
          acc_row_q <= start_val;
          x_q       <= x0_q;
          y_q       <= y0_q;
          x_end_q   <= x0_q + w_q - ONE;
          y_end_q   <= y0_q + h_q - ONE;
          last_q    <= (w_q == ONE) && (h_q == ONE);
          if ((w_q == '0) || (h_q == '0)) begin
            done_q        <= 1'b1;
            setup_ready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.out_ready) begin
            if (last_q) begin
              out_valid_q   <= 1'b0;
              last_q        <= 1'b0;
              done_q        <= 1'b1;
              setup_ready_q <= 1'b1;
              state_q       <= ST_IDLE;
            end else if (x_q == x_end_q) begin
              // The next row starts from the updated row base, so no bubble is needed.
              x_q       <= x0_q;
              y_q       <= y_q + ONE;
              acc_row_q <= acc_row_d;
              acc_q     <= acc_row_d;
              last_q    <= (x0_q == x_end_q) && ((y_q + ONE) == y_end_q);
            end else begin
              x_q    <= x_q + ONE;
              acc_q  <= acc_q + sext_acc(ddx_q);
              last_q <= ((x_q + ONE) == x_end_q) && (y_q == y_end_q);
            end
          end
        end
        default: begin
          out_valid_q   <= 1'b0;
          last_q        <= 1'b0;
          setup_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.setup_ready = setup_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_x       = x_q;
  assign bus.out_y       = y_q;
  assign bus.out_interp  = acc_q[31:0];
  assign bus.out_last    = last_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_plane_interp_stepper.sv
// Directed bench for plane_interp_stepper: span table with hand-computed pixels or a
// direct-formula model, plus a mid-span reset sequence.
module tb_plane_interp_stepper;
  import plane_interp_stepper_pkg::*;

  typedef struct {
    logic signed [31:0]  ddx;
    logic signed [31:0]  ddy;
    logic signed [31:0]  c;
    logic [COORD_W-1:0]  x0;
    logic [COORD_W-1:0]  y0;
    logic [COORD_W-1:0]  w;
    logic [COORD_W-1:0]  h;
    int                  mode;
    int                  hand_base;
    int                  hand_n;
  } span_t;

  typedef struct {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [31:0]         interp;
    logic                last;
  } pixel_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  pixel_t hand_tab [8];
  span_t  span_tab [8];
  pixel_t exp_q [$];

  plane_interp_stepper_if bus ();

  plane_interp_stepper dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pack_pix(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                           input logic [31:0] v, input logic l);
    return {9'b0, x, y, v, l};
  endfunction

  function automatic logic [63:0] cur_pix();
    return pack_pix(bus.out_x, bus.out_y, bus.out_interp, bus.out_last);
  endfunction

  task automatic build_expected(input span_t s);
    longint v;
    logic [63:0] v64;
    pixel_t p;
    int n;
    exp_q.delete();
    if (s.hand_n > 0) begin
      for (int i = 0; i < s.hand_n; i++) exp_q.push_back(hand_tab[s.hand_base + i]);
    end else begin
      n = int'(s.w) * int'(s.h);
      for (int j = 0; j < int'(s.h); j++) begin
        for (int i = 0; i < int'(s.w); i++) begin
          p.x = s.x0 + COORD_W'(i);
          p.y = s.y0 + COORD_W'(j);
          v = longint'(p.x) * longint'(s.ddx) + longint'(p.y) * longint'(s.ddy) + longint'(s.c);
          v64 = v;
          p.interp = v64[31:0];
          p.last = (j * int'(s.w) + i) == (n - 1);
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic send_setup(input span_t s);
    @(negedge clk);
    bus.ddx = s.ddx;
    bus.ddy = s.ddy;
    bus.c = s.c;
    bus.x0 = s.x0;
    bus.y0 = s.y0;
    bus.width = s.w;
    bus.height = s.h;
    bus.setup_valid = 1'b1;
    chk("setup_ready_before_accept", {63'b0, bus.setup_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.setup_valid = 1'b0;
    chk("out_valid_in_init", {63'b0, bus.out_valid}, 64'd0);
  endtask

  task automatic run_span(input int sid, input span_t s);
    int idx, cyc, n;
    logic ready, prev_stall;
    logic [63:0] prev_pix;
    build_expected(s);
    n = exp_q.size();
    send_setup(s);
    @(posedge clk);
    #1;
    if (n == 0) begin
      chk("empty_done", {63'b0, bus.done}, 64'd1);
      chk("empty_no_valid", {63'b0, bus.out_valid}, 64'd0);
      chk("empty_setup_ready", {63'b0, bus.setup_ready}, 64'd1);
      @(posedge clk);
      #1;
      chk("empty_done_one_cycle", {63'b0, bus.done}, 64'd0);
      chk("empty_still_no_valid", {63'b0, bus.out_valid}, 64'd0);
    end else begin
      idx = 0;
      cyc = 0;
      prev_stall = 1'b0;
      prev_pix = '0;
      while (idx < n && cyc < 4 * n + 20) begin
        if (prev_stall) chk("stall_hold", cur_pix(), prev_pix);
        ready = (s.mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
        bus.out_ready = ready;
        chk("out_valid_run", {63'b0, bus.out_valid}, 64'd1);
        chk("done_during_span", {63'b0, bus.done}, 64'd0);
        chk("setup_ready_during_span", {63'b0, bus.setup_ready}, 64'd0);
        if (bus.out_valid && ready) begin
          if (cur_pix() !== pack_pix(exp_q[idx].x, exp_q[idx].y, exp_q[idx].interp, exp_q[idx].last))
            $display("span %0d pixel %0d differs", sid, idx);
          chk("pixel", cur_pix(),
              pack_pix(exp_q[idx].x, exp_q[idx].y, exp_q[idx].interp, exp_q[idx].last));
          idx++;
        end
        prev_stall = bus.out_valid && !ready;
        prev_pix = cur_pix();
        @(posedge clk);
        #1;
        cyc++;
      end
      if (idx < n) begin
        n_chk++;
        n_fail++;
        $display("FAIL span_timeout: span %0d got %0d pixels, expected %0d", sid, idx, n);
      end
      bus.out_ready = 1'b1;
      chk("end_done_pulse", {63'b0, bus.done}, 64'd1);
      chk("end_no_valid", {63'b0, bus.out_valid}, 64'd0);
      chk("end_setup_ready", {63'b0, bus.setup_ready}, 64'd1);
    end
    $display("span %0d: ddx=%h ddy=%h c=%h origin=(%0d,%0d) size=%0dx%0d mode=%0d pixels=%0d",
             sid, s.ddx, s.ddy, s.c, s.x0, s.y0, s.w, s.h, s.mode, n);
  endtask

  initial begin
    span_t s;
    bus.setup_valid = 1'b0;
    bus.ddx = '0;
    bus.ddy = '0;
    bus.c = '0;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.width = '0;
    bus.height = '0;
    bus.out_ready = 1'b1;

    hand_tab[0] = '{x: 11'd2, y: 11'd3, interp: 32'h0000_1800, last: 1'b0};
    hand_tab[1] = '{x: 11'd3, y: 11'd3, interp: 32'h0000_1900, last: 1'b0};
    hand_tab[2] = '{x: 11'd2, y: 11'd4, interp: 32'h0000_1A00, last: 1'b0};
    hand_tab[3] = '{x: 11'd3, y: 11'd4, interp: 32'h0000_1B00, last: 1'b1};
    hand_tab[4] = '{x: 11'd0, y: 11'd0, interp: 32'h0000_0000, last: 1'b0};
    hand_tab[5] = '{x: 11'd1, y: 11'd0, interp: 32'hFFFF_FF80, last: 1'b0};
    hand_tab[6] = '{x: 11'd2, y: 11'd0, interp: 32'hFFFF_FF00, last: 1'b0};
    hand_tab[7] = '{x: 11'd3, y: 11'd0, interp: 32'hFFFF_FE80, last: 1'b1};

    span_tab[0] = '{32'h100, 32'h200, 32'h1000, 11'd2, 11'd3, 11'd2, 11'd2, 0, 0, 4};
    span_tab[1] = '{32'h100, 32'h200, 32'h1000, 11'd2, 11'd3, 11'd2, 11'd2, 1, 0, 4};
    span_tab[2] = '{32'h100, 32'h200, 32'h1000, 11'd2, 11'd3, 11'd0, 11'd5, 0, 0, 0};
    span_tab[3] = '{-32'sh80, 32'h0, 32'h0, 11'd0, 11'd0, 11'd4, 11'd1, 0, 4, 4};
    span_tab[4] = '{32'h7FFF_FFFF, 32'h10, 32'h1234_5678, 11'd5, 11'd7, 11'd640, 11'd1, 0, 0, 0};
    span_tab[5] = '{32'h55, -32'sh123, -32'sd5, 11'd7, 11'd1, 11'd3, 11'd3, 1, 0, 0};
    span_tab[6] = '{32'h40, 32'h80, 32'hABC, 11'd9, 11'd11, 11'd1, 11'd1, 0, 0, 0};
    span_tab[7] = '{32'h40, 32'h80, 32'hABC, 11'd9, 11'd11, 11'd3, 11'd0, 0, 0, 0};

    #12;
    chk("reset_setup_ready", {63'b0, bus.setup_ready}, 64'd1);
    chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("reset_out_last", {63'b0, bus.out_last}, 64'd0);
    chk("reset_done", {63'b0, bus.done}, 64'd0);
    chk("reset_out_pix", cur_pix(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++) run_span(k, span_tab[k]);

    // Mid-span reset on the second pixel of a 4x4 span, then a clean rerun.
    s = '{32'h100, 32'h200, 32'h1000, 11'd1, 11'd1, 11'd4, 11'd4, 0, 0, 0};
    bus.out_ready = 1'b1;
    send_setup(s);
    @(posedge clk);
    #1;
    chk("rst_seq_first_pixel", cur_pix(), pack_pix(11'd1, 11'd1, 32'h1300, 1'b0));
    @(posedge clk);
    #1;
    chk("rst_seq_second_pixel", cur_pix(), pack_pix(11'd2, 11'd1, 32'h1400, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_async_setup_ready", {63'b0, bus.setup_ready}, 64'd1);
    chk("rst_async_out_pix", cur_pix(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_no_done", {63'b0, bus.done}, 64'd0);
      chk("rst_no_valid", {63'b0, bus.out_valid}, 64'd0);
    end
    $display("reset sequence: span discarded on pixel 2");
    run_span(8, span_tab[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
